// File: rtl/cv32e40p_fault_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_fault_pkg
// Description : Shared definitions for the fault monitor: group indices,
//               group count and the event-FIFO entry layout.
//               The entry carries a timestamp field only when
//               CV32E40P_FAULT_TIMESTAMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_fault_pkg;

  localparam int unsigned FLT_GRP_MEM  = 0;
  localparam int unsigned FLT_GRP_ECC  = 1;
  localparam int unsigned FLT_GRP_TMR  = 2;
  localparam int unsigned FLT_GRP_LS   = 3;
  localparam int unsigned FLT_GRP_ID   = 4;
  localparam int unsigned FLT_GRP_DIV  = 5;
  localparam int unsigned FLT_NUM_GRP  = 6;
  localparam int unsigned FLT_TS_WIDTH = 16;

`ifdef CV32E40P_FAULT_TIMESTAMP_EN
  typedef struct packed {
    logic [FLT_NUM_GRP-1:0]  mask;
    logic [FLT_TS_WIDTH-1:0] tstamp;
  } flt_entry_t;
`else
  typedef struct packed {
    logic [FLT_NUM_GRP-1:0] mask;
  } flt_entry_t;
`endif

endpackage
`default_nettype wire

// File: rtl/cv32e40p_fault_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_fault_fifo
// Description : Event FIFO for the fault monitor. No write-to-read bypass:
//               an entry pushed into an empty FIFO is visible next cycle.
//               flush_i empties the FIFO; a same-cycle push is kept as the
//               sole entry.
// Ports       : clk_i, rst_ni      clock / async active-low reset
//               flush_i            synchronous flush
//               push_i, data_i     write side (no backpressure; drops when full)
//               ready_i, valid_o,  read handshake, data_o is head entry
//               data_o
//               drop_o             push discarded this cycle (full, no pop)
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_fault_fifo
  import cv32e40p_fault_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  flt_entry_t data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output flt_entry_t data_o,
  output logic       drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  flt_entry_t    mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW-1:0] waddr;
  logic          we;
  logic          pop;
  logic          full;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign valid_o = (wptr_q != rptr_q);
  assign pop     = valid_o && ready_i;
  // Gated so the head reads as zero while empty and during reset.
  assign data_o  = valid_o ? mem_q[rptr_q[AW-1:0]] : '0;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    waddr  = wptr_q[AW-1:0];
    we     = 1'b0;
    drop_o = 1'b0;
    if (flush_i) begin
      // Flush wins over any pop; a concurrent push lands in slot 0.
      rptr_d = '0;
      waddr  = '0;
      we     = push_i;
      wptr_d = {{AW{1'b0}}, push_i};
    end else begin
      // A pop in the same cycle frees the slot the push would overwrite.
      we     = push_i && (!full || pop);
      drop_o = push_i && full && !pop;
      rptr_d = rptr_q + {{AW{1'b0}}, pop};
      wptr_d = wptr_q + {{AW{1'b0}}, we};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[waddr] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cv32e40p_fault_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_fault_monitor
// Description : Collects fault flags from six core groups, detects rising
//               edges of group activity, and records them as sticky status,
//               saturating per-group counters, a level interrupt and an
//               event FIFO of {group mask, timestamp}.
// Config      : define CV32E40P_FAULT_TIMESTAMP_EN to add a 16-bit wrapping
//               cycle counter stored with each entry; otherwise evt_time_o
//               is tied to zero.
// Ports       : clk_i/rst_ni        clock, async active-low reset
//               *_err_i/*_error_i   group fault flags, div_out_*_i replicas
//               irq_mask_i          per-group irq enable
//               clear_i             sync clear of status/counters/FIFO
//               sticky_o/overflow_o status; irq_o level interrupt
//               evt_*               FIFO head and pop handshake
//               cnt_o               per-group counters, CNT_WIDTH each
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_fault_monitor
  import cv32e40p_fault_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [14:0]                      mem_err_i,
  input  logic [2:0]                       ecc_err_i,
  input  logic [8:0]                       tmr_mult_err_i,
  input  logic [4:0]                       l_s_error_i,
  input  logic [11:0]                      id_st_error_i,
  input  logic [32:0]                      div_out_0_i,
  input  logic [32:0]                      div_out_1_i,
  input  logic [32:0]                      div_out_2_i,
  input  logic [FLT_NUM_GRP-1:0]           irq_mask_i,
  input  logic                             clear_i,
  output logic [FLT_NUM_GRP-1:0]           sticky_o,
  output logic                             overflow_o,
  output logic                             irq_o,
  output logic                             evt_valid_o,
  input  logic                             evt_ready_i,
  output logic [FLT_NUM_GRP-1:0]           evt_mask_o,
  output logic [FLT_TS_WIDTH-1:0]          evt_time_o,
  output logic [FLT_NUM_GRP*CNT_WIDTH-1:0] cnt_o
);

  logic [FLT_NUM_GRP-1:0] grp_act;
  logic [FLT_NUM_GRP-1:0] grp_evt;
  logic [FLT_NUM_GRP-1:0] act_q;
  logic [FLT_NUM_GRP-1:0] sticky_q, sticky_d;
  logic                   overflow_q, overflow_d;
  logic                   irq_q, irq_d;
  logic                   fifo_drop;
  flt_entry_t             push_entry;
  flt_entry_t             head_entry;

  always_comb begin
    grp_act              = '0;
    grp_act[FLT_GRP_MEM] = |mem_err_i;
    grp_act[FLT_GRP_ECC] = |ecc_err_i;
    grp_act[FLT_GRP_TMR] = |tmr_mult_err_i;
    grp_act[FLT_GRP_LS]  = |l_s_error_i;
    grp_act[FLT_GRP_ID]  = |id_st_error_i;
    // Divider fault is replica disagreement, not a flag vector.
    grp_act[FLT_GRP_DIV] = (div_out_0_i != div_out_1_i) || (div_out_1_i != div_out_2_i);
  end

  // act_q resets to zero, so a group already active when reset releases
  // still produces an event on the first cycle.
  assign grp_evt = grp_act & ~act_q;

`ifdef CV32E40P_FAULT_TIMESTAMP_EN
  logic [FLT_TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + FLT_TS_WIDTH'(1);
    end
  end
`endif

  always_comb begin
    push_entry      = '0;
    push_entry.mask = grp_evt;
`ifdef CV32E40P_FAULT_TIMESTAMP_EN
    push_entry.tstamp = ts_q;
`endif
  end

  // Clear zeroes state first, then the same-cycle event is applied on top.
  always_comb begin
    sticky_d   = clear_i ? grp_evt : (sticky_q | grp_evt);
    overflow_d = clear_i ? 1'b0 : (overflow_q | fifo_drop);
    // Registered from the next sticky value so irq_o tracks sticky_o
    // in the same cycle while remaining a flop output.
    irq_d      = |(sticky_d & irq_mask_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q      <= '0;
      sticky_q   <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      act_q      <= grp_act;
      sticky_q   <= sticky_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  for (genvar g = 0; g < FLT_NUM_GRP; g++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = grp_evt[g] ? CNT_WIDTH'(1) : '0;
      end else if (grp_evt[g] && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

  cv32e40p_fault_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (|grp_evt),
    .data_i  (push_entry),
    .ready_i (evt_ready_i),
    .valid_o (evt_valid_o),
    .data_o  (head_entry),
    .drop_o  (fifo_drop)
  );

  assign sticky_o   = sticky_q;
  assign overflow_o = overflow_q;
  assign irq_o      = irq_q;
  assign evt_mask_o = head_entry.mask;
`ifdef CV32E40P_FAULT_TIMESTAMP_EN
  assign evt_time_o = head_entry.tstamp;
`else
  assign evt_time_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_fault_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_fault_monitor
// Description : Self-checking bench for cv32e40p_fault_monitor (FIFO_DEPTH=4,
//               CNT_WIDTH=4). A queue-based reference model tracks sticky
//               status, counters, overflow, irq and FIFO contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_fault_monitor;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] mem_err;
  logic [2:0]  ecc_err;
  logic [8:0]  tmr_err;
  logic [4:0]  ls_err;
  logic [11:0] id_err;
  logic [32:0] d0, d1, d2;
  logic [5:0]  irq_mask;
  logic        clear;
  logic        ready;
  logic [5:0]  sticky;
  logic        ovf;
  logic        irq;
  logic        evt_valid;
  logic [5:0]  evt_mask;
  logic [15:0] evt_time;
  logic [6*CW-1:0] cnt;

  always #5 clk = ~clk;

  cv32e40p_fault_monitor #(
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mem_err_i      (mem_err),
    .ecc_err_i      (ecc_err),
    .tmr_mult_err_i (tmr_err),
    .l_s_error_i    (ls_err),
    .id_st_error_i  (id_err),
    .div_out_0_i    (d0),
    .div_out_1_i    (d1),
    .div_out_2_i    (d2),
    .irq_mask_i     (irq_mask),
    .clear_i        (clear),
    .sticky_o       (sticky),
    .overflow_o     (ovf),
    .irq_o          (irq),
    .evt_valid_o    (evt_valid),
    .evt_ready_i    (ready),
    .evt_mask_o     (evt_mask),
    .evt_time_o     (evt_time),
    .cnt_o          (cnt)
  );

  typedef struct {
    logic [5:0]  mask;
    logic [15:0] ts;
  } ent_t;

  ent_t        mq[$];
  logic [5:0]  m_sticky;
  logic [5:0]  m_prev;
  bit          m_ovf;
  bit          m_irq;
  int          m_cnt[6];
  logic [15:0] m_ts;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sticky = '0;
    m_prev   = '0;
    m_ovf    = 1'b0;
    m_irq    = 1'b0;
    m_ts     = '0;
    for (int g = 0; g < 6; g++) m_cnt[g] = 0;
  endtask

  task automatic check_all(input string ph);
    logic [15:0] exp_ts;
    check({ph, "_sticky"}, 32'(sticky), 32'(m_sticky));
    check({ph, "_ovf"}, 32'(ovf), 32'(m_ovf));
    check({ph, "_irq"}, 32'(irq), 32'(m_irq));
    check({ph, "_valid"}, 32'(evt_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
`ifdef CV32E40P_FAULT_TIMESTAMP_EN
      exp_ts = mq[0].ts;
`else
      exp_ts = 16'h0;
`endif
      check({ph, "_mask"}, 32'(evt_mask), 32'(mq[0].mask));
      check({ph, "_time"}, 32'(evt_time), 32'(exp_ts));
    end
    for (int g = 0; g < 6; g++)
      check($sformatf("%s_cnt%0d", ph, g), 32'(cnt[g*CW +: CW]), 32'(m_cnt[g]));
  endtask

  task automatic idle();
    mem_err = '0; ecc_err = '0; tmr_err = '0; ls_err = '0; id_err = '0;
    d0 = '0; d1 = '0; d2 = '0;
    clear = 1'b0;
  endtask

  // Apply the current inputs for one clock, advance the model by the rules,
  // then compare everything just after the edge.
  task automatic step(input string ph);
    logic [5:0] act, evt;
    bit pop;
    act[0] = (mem_err != 0);
    act[1] = (ecc_err != 0);
    act[2] = (tmr_err != 0);
    act[3] = (ls_err != 0);
    act[4] = (id_err != 0);
    act[5] = !((d0 == d1) && (d1 == d2));
    evt    = act & ~m_prev;
    m_prev = act;
    pop    = (mq.size() != 0) && ready;
    if (clear) begin
      mq.delete();
      m_sticky = '0;
      m_ovf    = 1'b0;
      for (int g = 0; g < 6; g++) m_cnt[g] = 0;
    end else if (pop) begin
      void'(mq.pop_front());
    end
    for (int g = 0; g < 6; g++)
      if (evt[g] && m_cnt[g] < CMAX) m_cnt[g]++;
    m_sticky |= evt;
    if (evt != 0) begin
      if (mq.size() < DEPTH) mq.push_back('{evt, m_ts});
      else m_ovf = 1'b1;
    end
    m_irq = |(m_sticky & irq_mask);
    m_ts++;
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic set_grp(input int g);
    case (g)
      0: mem_err = 15'h0004;
      1: ecc_err = 3'b100;
      2: tmr_err = 9'h010;
      3: ls_err  = 5'h02;
      4: id_err  = 12'h800;
      default: d2 = 33'h1_0000_0000;
    endcase
  endtask

  initial begin
    rst_n    = 1'b1;
    ready    = 1'b0;
    irq_mask = '0;
    idle();
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");

    // Input already active in the first cycle after release; ECC held 5 cycles.
    @(negedge clk);
    rst_n    = 1'b1;
    ecc_err  = 3'b010;
    irq_mask = 6'h02;
    step("ecc1");
    check("ecc_sticky_const", 32'(sticky), 32'h02);
    check("ecc_irq_const", 32'(irq), 32'h1);
    repeat (4) step("ecc_hold");
    check("ecc_cnt1_const", 32'(cnt[1*CW +: CW]), 32'h1);
    check("ecc_mask_const", 32'(evt_mask), 32'h02);
    idle();
    ready = 1'b1;
    repeat (2) step("ecc_drain");
    check("ecc_one_entry", 32'(evt_valid), 32'h0);
    clear = 1'b1;
    step("clr1");
    clear = 1'b0;

    // Divider replica mismatch coincident with a memory fault.
    ready   = 1'b0;
    mem_err = 15'h0001;
    d1      = 33'h0_0000_0001;
    step("div_mem");
    check("divmem_mask_const", 32'(evt_mask), 32'h21);
    check("divmem_cnt0_const", 32'(cnt[0 +: CW]), 32'h1);
    check("divmem_cnt5_const", 32'(cnt[5*CW +: CW]), 32'h1);
    idle();
    step("div_mem_idle");
    clear = 1'b1;
    step("clr2");
    clear = 1'b0;

    // Six separate events with no reader: four kept, overflow set.
    for (int k = 0; k < 6; k++) begin
      set_grp(k);
      step("ovf_evt");
      idle();
      step("ovf_idle");
    end
    check("ovf_const", 32'(ovf), 32'h1);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_order_const", 32'(evt_mask), 32'(6'h01 << k));
      step("ovf_drain");
    end
    check("drain_empty", 32'(evt_valid), 32'h0);

    // Clear coinciding with a load/store rise while the FIFO is full.
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k != 3) set_grp(k);
      else set_grp(5);
      step("fill_evt");
      idle();
      step("fill_idle");
    end
    clear  = 1'b1;
    ls_err = 5'h01;
    step("clr_ls");
    check("clrls_ovf_const", 32'(ovf), 32'h0);
    check("clrls_sticky_const", 32'(sticky), 32'h08);
    check("clrls_cnt3_const", 32'(cnt[3*CW +: CW]), 32'h1);
    idle();
    ready = 1'b1;
    step("clrls_pop");
    check("clrls_single", 32'(evt_valid), 32'h0);
    clear = 1'b1;
    step("clr3");
    clear = 1'b0;

    // Counter saturation with CNT_WIDTH=4.
    for (int k = 0; k < 20; k++) begin
      tmr_err = 9'h001;
      step("sat_on");
      tmr_err = 9'h000;
      step("sat_off");
    end
    check("sat_cnt2_const", 32'(cnt[2*CW +: CW]), 32'hF);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [32:0] base;
      mem_err  = ($urandom_range(0, 5) == 0) ? 15'($urandom) : '0;
      ecc_err  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : '0;
      tmr_err  = ($urandom_range(0, 5) == 0) ? 9'($urandom) : '0;
      ls_err   = ($urandom_range(0, 5) == 0) ? 5'($urandom) : '0;
      id_err   = ($urandom_range(0, 5) == 0) ? 12'($urandom) : '0;
      base     = {1'($urandom), 32'($urandom)};
      d0       = base;
      d1       = base;
      d2       = ($urandom_range(0, 5) == 0) ? (base ^ (33'h1 << $urandom_range(0, 32))) : base;
      ready    = ($urandom_range(0, 2) == 0);
      clear    = ($urandom_range(0, 39) == 0);
      irq_mask = 6'($urandom);
      step("rand");
    end
    idle();

    // Asynchronous reset in the middle of a drain with three entries left.
    clear = 1'b1;
    ready = 1'b0;
    step("clr4");
    clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_grp(k);
      step("rst_fill");
      idle();
      step("rst_fill_idle");
    end
    ready = 1'b1;
    step("rst_drain");
    check("rst_pending3", 32'(mq.size()), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", 32'(evt_valid), 32'h0);
    check("arst_sticky", 32'(sticky), 32'h0);
    check("arst_cnt", 32'(cnt), 32'h0);
    check("arst_ovf", 32'(ovf), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b0;
    repeat (2) step("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cv32e40p_fault_monitor.md
CV32E40P_FAULT_MONITOR -- requirements
Module: cv32e40p_fault_monitor

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, at least 2.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, width of each per-group event counter.
REQ-003 clk_i  input  1  core clock; the block SHALL use this single clock.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 mem_err_i  input  15  memory fault flags from core top (group 0).
REQ-006 ecc_err_i  input  3  ECC fault flags (group 1).
REQ-007 tmr_mult_err_i  input  9  multiplier TMR fault flags (group 2).
REQ-008 l_s_error_i  input  5  load/store fault flags (group 3).
REQ-009 id_st_error_i  input  12  ID-stage fault flags (group 4).
REQ-010 div_out_0_i, div_out_1_i, div_out_2_i  input  33 each  divider replica outputs (group 5).
REQ-011 irq_mask_i  input  6  per-group interrupt enable.
REQ-012 clear_i  input  1  synchronous clear pulse.
REQ-013 sticky_o  output  6  per-group sticky fault status.
REQ-014 overflow_o  output  1  sticky event-FIFO overflow.
REQ-015 irq_o  output  1  fault interrupt, level.
REQ-016 evt_valid_o / evt_ready_i  output/input  1/1  event FIFO pop handshake.
REQ-017 evt_mask_o  output  6  group mask of head entry.
REQ-018 evt_time_o  output  16  timestamp of head entry.
REQ-019 cnt_o  output  6*CNT_WIDTH  per-group counters, group g at bits [g*CNT_WIDTH +: CNT_WIDTH].

Function
REQ-020 Group g SHALL be active when its input vector is nonzero; group 5 active when the three div replicas are not all equal.
REQ-021 A group event SHALL be a rising edge of group activity against a registered previous-activity flag.
REQ-022 An event in cycle N SHALL be visible on sticky_o, cnt_o, FIFO and irq_o in cycle N+1.
REQ-023 Each counter SHALL increment by 1 per event and saturate at all-ones.
REQ-024 Any cycle with at least one event SHALL push one entry {6-bit event mask, timestamp}.
REQ-025 Push while full with no same-cycle pop SHALL drop the entry and set overflow_o.
REQ-026 Push and pop in the same cycle SHALL both take effect, including when full or empty-with-bypass-disallowed (an entry pushed into an empty FIFO becomes valid the next cycle).
REQ-027 Pop SHALL occur when evt_valid_o and evt_ready_i are both high; evt_mask_o/evt_time_o SHALL hold stable while evt_valid_o is high and not popped.
REQ-028 irq_o SHALL equal OR of (sticky_o AND irq_mask_i), driven from registers only.
REQ-029 clear_i SHALL zero sticky_o, counters, overflow_o and flush the FIFO; a same-cycle event SHALL then be applied (sticky set, counter = 1, FIFO holds that single entry).
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy tracked with one extra pointer bit.

Reset
REQ-031 All outputs, counters, pointers, previous-activity flags and timestamp counter SHALL be 0 during reset.
REQ-032 An input active in the first cycle after reset release SHALL count as an event.

Configuration
REQ-033 With CV32E40P_FAULT_TIMESTAMP_EN defined, a 16-bit free-running wrapping cycle counter SHALL be stored per entry and drive evt_time_o.
REQ-034 Without CV32E40P_FAULT_TIMESTAMP_EN, the counter and timestamp storage SHALL be absent and evt_time_o SHALL be tied to 0.

Structure
REQ-035 Group-index constants (FLT_GRP_MEM..FLT_GRP_DIV), group count 6 and the FIFO entry struct SHALL live in a shared package cv32e40p_fault_pkg.
REQ-036 The FIFO SHALL be a sub-module cv32e40p_fault_fifo.

Verification
REQ-037 ecc_err_i=3'b010 held 5 cycles, irq_mask_i=6'h02 -> sticky_o=6'h02, group-1 counter=1, one entry mask 6'h02, irq_o=1 next cycle.
REQ-038 div_out_1_i differs from the other two replicas for one cycle while mem_err_i rises in the same cycle -> one entry with mask 6'h21; counters of groups 0 and 5 each equal 1.
REQ-039 Six separate events with evt_ready_i=0, FIFO_DEPTH=4 -> 4 entries kept, overflow_o=1; drain yields the first four masks in order.
REQ-040 clear_i in the same cycle as an l_s_error_i rise with a full FIFO -> overflow_o=0, sticky_o=6'h08, group-3 counter=1, exactly one entry.
REQ-041 CNT_WIDTH=4, 20 pulses on tmr_mult_err_i -> group-2 counter = 4'hF.
REQ-042 rst_ni asserted mid-drain with three entries pending -> evt_valid_o=0, all counters and sticky_o=0 immediately (asynchronous).
